// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/HALT control, pc sequencing, redirect and stall handling.
// Optional build macro FETCH_PERF_CNT_EN adds a 16-bit accepted-fetch counter output.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] pc_out,
  output logic        instr_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic {FETCH, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        accept;

  assign imem_req  = (state_q == FETCH) && !stall;
  assign imem_addr = pc_q;
  // A redirect in the same cycle as ready wins: the returned word belongs to the wrong path.
  assign accept    = imem_req && imem_ready && !redirect_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = 1'b0;
    if (state_q == FETCH) begin
      if (redirect_valid) begin
        pc_d = redirect_pc & 16'hFFFE;
      end else if (accept) begin
        instr_d  = imem_rdata;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 16'd2;
        if (imem_rdata[15:12] == 4'b0000) state_d = HALT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= 16'h0000;
      instr_q  <= 16'h0000;
      pc_out_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count_q <= 16'h0000;
    else if (accept) count_q <= count_q + 16'd1;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .instr          (instr),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of architecturally visible state.
  logic [15:0] m_pc, m_instr, m_pc_out, m_cnt;
  logic        m_valid, m_halt;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc_out = 16'h0000;
    m_cnt = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic set_in(input logic [15:0] rd, input logic rdy, input logic st,
                        input logic rv, input logic [15:0] rp);
    imem_rdata = rd; imem_ready = rdy; stall = st; redirect_valid = rv; redirect_pc = rp;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit take;
    take = !m_halt && !stall && imem_ready && !redirect_valid;
    m_valid = take;
    if (!m_halt && redirect_valid) m_pc = {redirect_pc[15:1], 1'b0};
    if (take) begin
      m_instr  = imem_rdata;
      m_pc_out = m_pc;
      m_pc     = m_pc + 16'd2;
      m_cnt    = m_cnt + 16'd1;
      if (imem_rdata[15:12] == 4'h0) m_halt = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h want 0000", instr); end
    n_tests++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc_out: got %h want 0000", pc_out); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    n_tests++; if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL rst_count: got %h want 0000", fetch_count); end
`endif
    release_reset();
  endtask

  task automatic test_sequence();
    logic [15:0] words [3];
    words[0] = 16'hF123; words[1] = 16'h8004; words[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      set_in(words[i], 1'b1, 1'b0, 1'b0, 16'h0000);
      n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req%0d: got %b want 1", i, imem_req); end
      n_tests++; if (imem_addr !== 16'(2 * i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 16'(2 * i)); end
      tick();
      n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b want 1", i, instr_valid); end
      n_tests++; if (pc_out !== 16'(2 * i)) begin n_fail++; $display("FAIL seq_pc_out%0d: got %h want %h", i, pc_out, 16'(2 * i)); end
      n_tests++; if (instr !== words[i]) begin n_fail++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, words[i]); end
      n_tests++; if (opcode !== words[i][15:12]) begin n_fail++; $display("FAIL seq_opcode%0d: got %h want %h", i, opcode, words[i][15:12]); end
    end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL seq_halted: got %b want 1", halted); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_halt: got %b want 0", imem_req); end
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_no_pulse: got %b want 0", instr_valid); end
    n_tests++; if (imem_addr !== 16'h0006) begin n_fail++; $display("FAIL seq_pc_frozen: got %h want 0006", imem_addr); end
  endtask

  task automatic test_wait();
    apply_reset();
    release_reset();
    set_in(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin n_fail++; $display("FAIL wait_hold%0d: got req=%b addr=%h want req=1 addr=0010", i, imem_req, imem_addr); end
      tick();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid%0d: got %b want 0", i, instr_valid); end
    end
    set_in(16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    n_tests++; if (instr_valid !== 1'b1 || pc_out !== 16'h0010 || instr !== 16'h1234) begin n_fail++; $display("FAIL wait_accept: got v=%b pc=%h i=%h want v=1 pc=0010 i=1234", instr_valid, pc_out, instr); end
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    n_tests++; if (instr_valid !== 1'b0 || instr !== 16'h1234) begin n_fail++; $display("FAIL wait_single: got v=%b i=%h want v=0 i=1234", instr_valid, instr); end
  endtask

  task automatic test_redirect();
    set_in(16'h5555, 1'b1, 1'b0, 1'b1, 16'h0041);
    tick();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
    n_tests++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_addr: got %h want 0040", imem_addr); end
    n_tests++; if (instr !== 16'h1234) begin n_fail++; $display("FAIL redir_instr_hold: got %h want 1234", instr); end
  endtask

  task automatic test_stall();
    set_in(16'h0000, 1'b0, 1'b1, 1'b1, 16'h0020);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(16'h7777, 1'b1, 1'b1, 1'b0, 16'h0000);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req); end
      tick();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid%0d: got %b want 0", i, instr_valid); end
    end
    set_in(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=0020", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    set_in(16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    tick();
    set_in(16'hF000, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    n_tests++; if (instr_valid !== 1'b1 || pc_out !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_accept: got v=%b pc=%h want v=1 pc=fffe", instr_valid, pc_out); end
    n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    n_tests++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL wrap_count: got %h want %h", fetch_count, m_cnt); end
`endif
  endtask

  task automatic test_halt_reset();
    set_in(16'h0ABC, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    n_tests++; if (halted !== 1'b1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL hr_enter: got h=%b v=%b want h=1 v=1", halted, instr_valid); end
    set_in(16'h1111, 1'b1, 1'b0, 1'b1, 16'h1234);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hr_req: got %b want 0", imem_req); end
    tick();
    n_tests++; if (imem_addr !== 16'h0002 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL hr_ignore: got addr=%h v=%b want addr=0002 v=0", imem_addr, instr_valid); end
    apply_reset();
    n_tests++; if (instr !== 16'h0000 || pc_out !== 16'h0000 || halted !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL hr_reset: got i=%h pc=%h h=%b a=%h v=%b want all zero", instr, pc_out, halted, imem_addr, instr_valid);
    end
    release_reset();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL hr_release: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [15:0] rd, rp;
    logic        rdy, st, rv;
    for (int c = 0; c < 500; c++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        apply_reset();
        release_reset();
      end
      rd  = 16'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rp  = 16'($urandom);
      set_in(rd, rdy, st, rv, rp);
      n_tests++; if (imem_req !== (!m_halt && !st) || imem_addr !== m_pc || halted !== m_halt) begin
        n_fail++; $display("FAIL rnd_comb c%0d: got req=%b a=%h h=%b want req=%b a=%h h=%b", c, imem_req, imem_addr, halted, !m_halt && !st, m_pc, m_halt);
      end
      tick();
      n_tests++; if (instr_valid !== m_valid || instr !== m_instr || pc_out !== m_pc_out || opcode !== m_instr[15:12]) begin
        n_fail++; $display("FAIL rnd_reg c%0d: got v=%b i=%h pc=%h want v=%b i=%h pc=%h", c, instr_valid, instr, pc_out, m_valid, m_instr, m_pc_out);
      end
`ifdef FETCH_PERF_CNT_EN
      n_tests++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count c%0d: got %h want %h", c, fetch_count, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wait();
    test_redirect();
    test_stall();
    test_wrap();
    test_halt_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
